// File: rtl/rect_fill_ctrl_pkg.sv
// Shared graphics definitions: framebuffer geometry, fill FSM encoding,
// rectangle payload and small unsigned helpers.
package rect_fill_ctrl_pkg;

  localparam int unsigned COORD_W   = 16;
  localparam int unsigned FB_XW_DEF = 9;
  localparam int unsigned FB_YW_DEF = 8;
  localparam int unsigned FB_X_MAX  = 511;
  localparam int unsigned FB_Y_MAX  = 255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_WAIT_BLANK = 3'd2,
    ST_FILL       = 3'd3,
    ST_DONE       = 3'd4
  } fill_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
  } rect_t;

  function automatic logic [COORD_W-1:0] umin16(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] umax16(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Largest framebuffer coordinate for an address width, as a 16-bit value
  function automatic logic [COORD_W-1:0] bound16(input int unsigned w);
    return COORD_W'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rect_cursor.sv
// Rectangle bounds registers and raster-order write cursor.
// Bounds are sorted and clamped to the framebuffer on load.
module rect_cursor
  import rect_fill_ctrl_pkg::*;
#(
  parameter int unsigned XW = FB_XW_DEF,
  parameter int unsigned YW = FB_YW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic          advance_i,
  input  rect_t         rect_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_c_o,
  output logic          empty_c_o
);

  localparam logic [COORD_W-1:0] XB = bound16(XW);
  localparam logic [COORD_W-1:0] YB = bound16(YW);

  logic [COORD_W-1:0] xlo_c, xhi_c, ylo_c, yhi_c;
  logic [XW-1:0]      xmin_q, xmax_q, x_q;
  logic [YW-1:0]      ymin_q, ymax_q, y_q;

  always_comb begin
    xlo_c = umin16(rect_i.x1, rect_i.x2);
    xhi_c = umax16(rect_i.x1, rect_i.x2);
    ylo_c = umin16(rect_i.y1, rect_i.y2);
    yhi_c = umax16(rect_i.y1, rect_i.y2);
  end

  // A rectangle whose low corner is off-screen has no visible pixels
  assign empty_c_o = (xlo_c > XB) || (ylo_c > YB);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (load_i) begin
      xmin_q <= XW'(xlo_c);
      xmax_q <= (xhi_c > XB) ? XW'(XB) : XW'(xhi_c);
      ymin_q <= YW'(ylo_c);
      ymax_q <= (yhi_c > YB) ? YW'(YB) : YW'(yhi_c);
      x_q    <= XW'(xlo_c);
      y_q    <= YW'(ylo_c);
    end else if (advance_i) begin
      // Row wrap; y saturates at ymax so the counter never leaves the bounds
      if (x_q == xmax_q) begin
        x_q <= xmin_q;
        if (y_q != ymax_q) begin
          y_q <= y_q + YW'(1);
        end
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign last_c_o = (x_q == xmax_q) && (y_q == ymax_q);

endmodule

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill controller: streams one framebuffer write per permitted
// cycle across a clamped rectangle in raster order.
module rect_fill_ctrl
  import rect_fill_ctrl_pkg::*;
#(
  parameter int unsigned FB_XW      = FB_XW_DEF,
  parameter int unsigned FB_YW      = FB_YW_DEF,
  parameter bit          BLANK_ONLY = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_fill_i,
  input  logic               fill_value_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  input  logic [COORD_W-1:0] x2_i,
  input  logic [COORD_W-1:0] y2_i,
  input  logic               abort_i,
  input  logic               blanking_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wr_en_o,
  output logic [FB_XW-1:0]   wr_x_o,
  output logic [FB_YW-1:0]   wr_y_o,
  output logic               wr_value_o
);

  fill_state_e        state_q, state_d;
  rect_t              rect_q, rect_d;
  logic               value_q, value_d;
  logic               ready_q, busy_q, done_q;
  logic               wr_en_q, wr_en_d;
  logic [FB_XW-1:0]   wr_x_q, wr_x_d;
  logic [FB_YW-1:0]   wr_y_q, wr_y_d;
  logic               wr_value_q, wr_value_d;

  logic               load_c, advance_c, write_ok_c;
  logic               cur_last_c, cur_empty_c;
  logic [FB_XW-1:0]   cur_x;
  logic [FB_YW-1:0]   cur_y;

  rect_cursor #(
    .XW (FB_XW),
    .YW (FB_YW)
  ) u_cursor (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (load_c),
    .advance_i (advance_c),
    .rect_i    (rect_q),
    .x_o       (cur_x),
    .y_o       (cur_y),
    .last_c_o  (cur_last_c),
    .empty_c_o (cur_empty_c)
  );

  assign write_ok_c = blanking_i || !BLANK_ONLY;

  // Next state, latched request and write-port decisions
  always_comb begin
    state_d    = state_q;
    rect_d     = rect_q;
    value_d    = value_q;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_value_d = wr_value_q;
    load_c     = 1'b0;
    advance_c  = 1'b0;

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_fill_i && !abort_i) begin
            rect_d  = '{x1: x1_i, y1: y1_i, x2: x2_i, y2: y2_i};
            value_d = fill_value_i;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cur_empty_c) begin
            state_d = ST_DONE;
          end else begin
            load_c  = 1'b1;
            state_d = BLANK_ONLY ? ST_WAIT_BLANK : ST_FILL;
          end
        end
        ST_WAIT_BLANK: begin
          if (blanking_i) begin
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          // Without write permission the cursor simply holds
          if (write_ok_c) begin
            wr_en_d    = 1'b1;
            wr_x_d     = cur_x;
            wr_y_d     = cur_y;
            wr_value_d = value_q;
            advance_c  = 1'b1;
            if (cur_last_c) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      rect_q     <= '0;
      value_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_value_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rect_q     <= rect_d;
      value_q    <= value_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_value_q <= wr_value_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_en_o    = wr_en_q;
  assign wr_x_o     = wr_x_q;
  assign wr_y_o     = wr_y_q;
  assign wr_value_o = wr_value_q;

endmodule
